ecc_seq_ctrl: RTL and testbench
===============================

// Module: ecc_seq_ctrl
// PURPOSE
//  Sequencer for the shared modular ALU. One start pulse runs one full scalar multiplication:
//  PRE-CAL -> double-and-add chain over the scalar bits -> modular-inversion chain (Fermat, exp q-2) -> DIV-MUL.
//  It drives the ALU's command inputs and tracks its per-operation ready pulses. It contains no datapath.
// PARAMETERS
//  SCALAR_W  255                 scalar bits walked, MSB first
//  INV_W     255                 inversion exponent width
//  INV_EXP   255'h7FF..FFEB      inversion exponent (q-2, q=2^255-19), MSB first
// PORTS
//  clk             in   1        clock, rising edge
//  rst             in   1        asynchronous reset, active-high
//  start           in   1        1-cycle request; accepted only in IDLE
//  scalar          in   SCALAR_W scalar k; captured in the start cycle
//  busy            out  1        high from the cycle after start accept until done
//  done            out  1        1-cycle pulse, whole sequence complete
//  phase           out  3        0 IDLE,1 PRE,2 MUL,3 INV,4 DIVMUL,5 DONE (operand-mux/debug use)
//  bit_idx         out  8        current bit index in MUL/INV, else 0
//  alu_valid       out  1        ALU in_valid (launch pulse)
//  alu_state       out  2        ALU in_state: 0 PRE-CAL,1 DOUBLE,2 DIV-INV,3 DIV-MUL
//  alu_keep        out  1        ALU in_keep_flag
//  alu_consec      out  1        ALU in_consecutive_flag
//  alu_ready       in   1        ALU out_ready: last cycle of one op (one scalar/exp bit in chains)
// BEHAVIOUR
//  Reset (async, any time incl. mid-sequence): FSM=IDLE; busy,done,alu_valid,alu_keep,alu_consec=0;
//   alu_state=0, phase=0, bit_idx=0, captured scalar=0. The ALU is reset by the same rst.
//  FSM: IDLE -start-> PRE -ready-> MUL -ready@idx0-> INV -ready@idx0-> DIVMUL -ready-> DONE -> IDLE.
//  Launch: alu_valid=1 for exactly the first cycle of PRE, MUL, INV, DIVMUL (ALU idle then);
//   alu_state is constant for the whole phase (PRE 0, MUL 1, INV 2, DIVMUL 3).
//  MUL: bit_idx loads SCALAR_W-1 on entry; alu_consec=k[bit_idx] (double followed by add);
//   alu_keep=(bit_idx!=0). On each alu_ready: bit_idx-1; at bit_idx=0, go to INV.
//  INV: bit_idx loads INV_W-1; alu_consec=INV_EXP[bit_idx] (square then multiply);
//   alu_keep=(bit_idx!=0); same decrement/exit rule.
//  PRE/DIVMUL: alu_keep=0, alu_consec=0; leave on first alu_ready.
//  Flags are registered-state decodes and stay stable for an entire ALU op; the ALU samples them
//   at its op's last cycle, the same cycle bit_idx updates on its clock edge.
//  DONE: done=1 for one cycle, busy=0 that cycle; back to IDLE next cycle.
//  Exactly SCALAR_W MUL readies and INV_W INV readies per run; k=0 still walks all bits.
//  start while busy or in DONE: ignored, scalar not recaptured.
//  alu_ready in IDLE/DONE or in the launch cycle of a phase: ignored (protocol error, no state change).
//  start and a stray alu_ready in IDLE, same cycle: start wins.
//  No timeout. A missing ready stalls the FSM until reset.
// TESTING (behavioural ALU model: ready after 4/10(9)/8 cycles as per op; SCALAR_W=4, INV_W=3, INV_EXP=3'b101)
//  1 rst held, then released -> all outputs 0, phase=0. Assert rst mid-MUL -> same next instant, no done.
//  2 start,k=4'b1011 -> alu_valid pulses at PRE/MUL/INV/DIVMUL entries only.
//    MUL alu_consec per bit 1,0,1,1 and alu_keep 1,1,1,0; one done pulse at the end.
//  3 INV phase -> alu_consec 1,0,1, alu_keep 1,1,0, bit_idx 2,1,0; then alu_state=3 with 1 launch.
//  4 start re-pulsed every cycle during a run with k=4'b0000 -> no restart; 4 MUL readies still counted;
//    done once.
//  5 spurious alu_ready in IDLE and in a launch cycle -> phase/bit_idx unchanged.
//  6 back-to-back runs: start in the cycle after done -> accepted; new k captured; second done delivered.

Source files
------------

// File: rtl/ecc_seq_ctrl.sv
// Scalar-multiplication sequencer for the shared modular ALU: PRE-CAL, double-and-add
// over the scalar, Fermat inversion chain, then DIV-MUL. Control only, no datapath.
module ecc_seq_ctrl #(
   parameter int                 SCALAR_W = 255,
   parameter int                 INV_W    = 255,
   parameter logic [INV_W-1:0]   INV_EXP  =
      255'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFEB
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [SCALAR_W-1:0] scalar,
   output logic                busy,
   output logic                done,
   output logic [2:0]          phase,
   output logic [7:0]          bit_idx,
   output logic                alu_valid,
   output logic [1:0]          alu_state,
   output logic                alu_keep,
   output logic                alu_consec,
   input  logic                alu_ready
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PRE    = 3'd1,
      S_MUL    = 3'd2,
      S_INV    = 3'd3,
      S_DIVMUL = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   localparam logic [7:0] MUL_TOP = 8'(SCALAR_W - 1);
   localparam logic [7:0] INV_TOP = 8'(INV_W - 1);

   state_t                state;
   logic [SCALAR_W-1:0]   scalar_q;
   logic [7:0]            idx_dec;
   logic [SCALAR_W-1:0]   mul_sh;
   logic [INV_W-1:0]      inv_sh;
   logic                  op_end;

   // A ready coinciding with the launch pulse cannot belong to the op being launched.
   assign op_end = alu_ready && !alu_valid;
   assign phase  = state;

   always_comb begin
      idx_dec = bit_idx - 8'd1;
      mul_sh  = scalar_q >> idx_dec;
      inv_sh  = INV_EXP >> idx_dec;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         scalar_q   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         bit_idx    <= 8'd0;
         alu_valid  <= 1'b0;
         alu_state  <= 2'd0;
         alu_keep   <= 1'b0;
         alu_consec <= 1'b0;
      end else begin
         // NOTE: pulse outputs default low here so every branch below only states when they fire.
         alu_valid <= 1'b0;
         done      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_PRE;
                  scalar_q   <= scalar;
                  busy       <= 1'b1;
                  alu_valid  <= 1'b1;
                  alu_state  <= 2'd0;
                  bit_idx    <= 8'd0;
                  alu_keep   <= 1'b0;
                  alu_consec <= 1'b0;
               end
            end
            S_PRE: begin
               if (op_end) begin
                  state      <= S_MUL;
                  alu_valid  <= 1'b1;
                  alu_state  <= 2'd1;
                  bit_idx    <= MUL_TOP;
                  alu_consec <= scalar_q[SCALAR_W-1];
                  alu_keep   <= (MUL_TOP != 8'd0);
               end
            end
            S_MUL: begin
               if (op_end) begin
                  if (bit_idx == 8'd0) begin
                     state      <= S_INV;
                     alu_valid  <= 1'b1;
                     alu_state  <= 2'd2;
                     bit_idx    <= INV_TOP;
                     alu_consec <= INV_EXP[INV_W-1];
                     alu_keep   <= (INV_TOP != 8'd0);
                  end else begin
                     bit_idx    <= idx_dec;
                     alu_consec <= mul_sh[0];
                     alu_keep   <= (idx_dec != 8'd0);
                  end
               end
            end
            S_INV: begin
               if (op_end) begin
                  if (bit_idx == 8'd0) begin
                     state      <= S_DIVMUL;
                     alu_valid  <= 1'b1;
                     alu_state  <= 2'd3;
                     bit_idx    <= 8'd0;
                     alu_consec <= 1'b0;
                     alu_keep   <= 1'b0;
                  end else begin
                     bit_idx    <= idx_dec;
                     alu_consec <= inv_sh[0];
                     alu_keep   <= (idx_dec != 8'd0);
                  end
               end
            end
            S_DIVMUL: begin
               if (op_end) begin
                  state     <= S_DONE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  alu_state <= 2'd0;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ecc_seq_ctrl.sv
// Self-checking bench for ecc_seq_ctrl: behavioural ALU, op-list reference model,
// randomized scalars, repeated starts and stray readies.
module tb_ecc_seq_ctrl;

   localparam int            SW  = 4;
   localparam int            IW  = 3;
   localparam logic [IW-1:0] EXP = 3'b101;

   logic          clk, rst, start;
   logic [SW-1:0] scalar;
   logic          busy, done;
   logic [2:0]    phase;
   logic [7:0]    bit_idx;
   logic          alu_valid;
   logic [1:0]    alu_state;
   logic          alu_keep, alu_consec, alu_ready;

   ecc_seq_ctrl #(.SCALAR_W(SW), .INV_W(IW), .INV_EXP(EXP)) dut (
      .clk(clk), .rst(rst), .start(start), .scalar(scalar),
      .busy(busy), .done(done), .phase(phase), .bit_idx(bit_idx),
      .alu_valid(alu_valid), .alu_state(alu_state), .alu_keep(alu_keep),
      .alu_consec(alu_consec), .alu_ready(alu_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One entry per ALU operation the run must issue, in order.
   typedef struct packed {
      logic [2:0] ph;
      logic [7:0] idx;
      logic       consec;
      logic       keep;
   } op_t;
   typedef enum int {M_IDLE, M_RUN, M_DONE} mst_t;

   op_t  q[$];
   mst_t mst;
   bit   m_launch;

   int n_vec, n_miss;

   bit            drv_start, drv_rst, drv_force_rdy, spur_en;
   logic [SW-1:0] drv_k;

   bit a_act, a_keep_rdy;
   int a_rem;

   int         valid_cnt, div_launch_cnt, done_cnt, mul_rdy_cnt, inv_rdy_cnt;
   logic [7:0] mul_consec_tr, mul_keep_tr, inv_consec_tr, inv_keep_tr;
   logic [23:0] inv_idx_tr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lat(input logic [1:0] st, input logic c);
      case (st)
         2'd0:    return 4;
         2'd1:    return c ? 10 : 9;
         default: return 8;
      endcase
   endfunction

   function automatic logic [31:0] expected();
      op_t h;
      case (mst)
         M_RUN: begin
            h = q[0];
            return 32'({h.ph, h.idx, 1'b1, 1'b0, m_launch, 2'(h.ph - 3'd1), h.keep, h.consec});
         end
         M_DONE:  return 32'({3'd5, 8'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0});
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] dut_outs();
      return 32'({phase, bit_idx, busy, done, alu_valid, alu_state, alu_keep, alu_consec});
   endfunction

   task automatic model_start(input logic [SW-1:0] k);
      op_t           o;
      logic [SW-1:0] ks;
      logic [IW-1:0] es;
      q.delete();
      o = '{ph: 3'd1, idx: 8'd0, consec: 1'b0, keep: 1'b0};
      q.push_back(o);
      for (int i = SW - 1; i >= 0; i--) begin
         ks = k >> i;
         o  = '{ph: 3'd2, idx: 8'(i), consec: ks[0], keep: (i != 0)};
         q.push_back(o);
      end
      for (int i = IW - 1; i >= 0; i--) begin
         es = EXP >> i;
         o  = '{ph: 3'd3, idx: 8'(i), consec: es[0], keep: (i != 0)};
         q.push_back(o);
      end
      o = '{ph: 3'd4, idx: 8'd0, consec: 1'b0, keep: 1'b0};
      q.push_back(o);
      mst      = M_RUN;
      m_launch = 1'b1;
   endtask

   task automatic clear_traces();
      valid_cnt = 0; div_launch_cnt = 0; done_cnt = 0; mul_rdy_cnt = 0; inv_rdy_cnt = 0;
      mul_consec_tr = '0; mul_keep_tr = '0; inv_consec_tr = '0; inv_keep_tr = '0;
      inv_idx_tr = '0;
   endtask

   // One clock: compare at the falling edge, drive ALU/start, then advance the model.
   task automatic cycle();
      logic [2:0] old_ph;
      @(negedge clk);
      check("outputs", dut_outs(), expected());
      if (alu_valid) valid_cnt++;
      if (alu_valid && alu_state == 2'd3) div_launch_cnt++;
      if (done) done_cnt++;
      if (drv_rst) begin
         a_act     = 1'b0;
         alu_ready = 1'b0;
      end else begin
         if (alu_valid) begin
            a_act = 1'b1;
            a_rem = lat(alu_state, alu_consec);
         end else if (a_act) begin
            if (a_rem == 1) begin
               if (a_keep_rdy) a_rem = lat(alu_state, alu_consec);
               else            a_act = 1'b0;
            end else begin
               a_rem--;
            end
         end
         alu_ready = a_act && (a_rem == 1);
         if (alu_ready) a_keep_rdy = alu_keep;
         if (spur_en && (phase == 3'd0 || phase == 3'd5 || alu_valid) &&
             $urandom_range(0, 2) == 0)
            alu_ready = 1'b1;
         if (drv_force_rdy && phase == 3'd0) alu_ready = 1'b1;
      end
      if (alu_ready && !alu_valid && phase == 3'd2) begin
         mul_rdy_cnt++;
         mul_consec_tr = {mul_consec_tr[6:0], alu_consec};
         mul_keep_tr   = {mul_keep_tr[6:0], alu_keep};
      end
      if (alu_ready && !alu_valid && phase == 3'd3) begin
         inv_rdy_cnt++;
         inv_consec_tr = {inv_consec_tr[6:0], alu_consec};
         inv_keep_tr   = {inv_keep_tr[6:0], alu_keep};
         inv_idx_tr    = {inv_idx_tr[15:0], bit_idx};
      end
      rst    = drv_rst;
      start  = drv_start;
      scalar = drv_start ? drv_k : SW'($urandom);
      @(posedge clk);
      if (rst) begin
         mst = M_IDLE; q.delete(); m_launch = 1'b0;
      end else begin
         case (mst)
            M_IDLE: if (start) model_start(scalar);
            M_RUN: begin
               if (alu_ready && !m_launch) begin
                  old_ph = q[0].ph;
                  void'(q.pop_front());
                  if (q.size() == 0) begin
                     mst = M_DONE; m_launch = 1'b0;
                  end else begin
                     m_launch = (q[0].ph != old_ph);
                  end
               end else begin
                  m_launch = 1'b0;
               end
            end
            default: mst = M_IDLE;
         endcase
      end
   endtask

   task automatic async_reset();
      @(negedge clk);
      drv_rst = 1'b1;
      rst     = 1'b1;
      #1;
      check("rst_immediate", dut_outs(), 32'd0);
      mst = M_IDLE; q.delete(); m_launch = 1'b0;
      a_act = 1'b0; alu_ready = 1'b0; drv_start = 1'b0;
      cycle();
      drv_rst = 1'b0;
      cycle();
   endtask

   task automatic run_seq(input logic [SW-1:0] k, input bit spam, input bit mid_rst);
      int cyc;
      bit do_rst;
      do_rst        = mid_rst;
      drv_start     = 1'b1;
      drv_k         = k;
      drv_force_rdy = 1'b1;
      cycle();
      drv_force_rdy = 1'b0;
      cyc = 0;
      while (mst != M_IDLE && cyc < 400) begin
         if (do_rst && mst == M_RUN && q[0].ph == 3'd2 && q[0].idx == 8'd2) begin
            async_reset();
            do_rst = 1'b0;
         end else begin
            drv_start = spam;
            drv_k     = SW'($urandom);
            cycle();
         end
         cyc++;
      end
      drv_start = 1'b0;
      check("run_bounded", 32'(cyc < 400), 32'd1);
   endtask

   initial begin
      n_vec = 0; n_miss = 0;
      rst = 1'b1; start = 1'b0; scalar = '0; alu_ready = 1'b0;
      drv_rst = 1'b1; drv_start = 1'b0; drv_force_rdy = 1'b0; spur_en = 1'b0; drv_k = '0;
      a_act = 1'b0; a_keep_rdy = 1'b0; a_rem = 0;
      mst = M_IDLE; m_launch = 1'b0;
      clear_traces();

      repeat (3) cycle();
      drv_rst = 1'b0;
      repeat (3) cycle();
      check("idle_after_rst", dut_outs(), 32'd0);

      spur_en = 1'b1;
      repeat (6) cycle();

      // Reference run, k = 1011, pinned with hand-derived traces.
      clear_traces();
      run_seq(4'b1011, 1'b0, 1'b0);
      check("mul_consec_trace", 32'(mul_consec_tr), 32'h0B);
      check("mul_keep_trace",   32'(mul_keep_tr),   32'h0E);
      check("inv_consec_trace", 32'(inv_consec_tr), 32'h05);
      check("inv_keep_trace",   32'(inv_keep_tr),   32'h06);
      check("inv_idx_trace",    32'(inv_idx_tr),    32'h020100);
      check("launch_count",     32'(valid_cnt),     32'd4);
      check("divmul_launches",  32'(div_launch_cnt), 32'd1);
      check("done_count_1011",  32'(done_cnt),      32'd1);

      // k = 0 with start held high throughout; immediately follows the previous done.
      clear_traces();
      run_seq(4'b0000, 1'b1, 1'b0);
      check("mul_readies_k0", 32'(mul_rdy_cnt), 32'd4);
      check("inv_readies_k0", 32'(inv_rdy_cnt), 32'd3);
      check("done_count_k0",  32'(done_cnt),    32'd1);

      // Reset in the middle of the MUL chain: no done may appear.
      clear_traces();
      run_seq(4'b0110, 1'b0, 1'b1);
      check("no_done_after_rst", 32'(done_cnt), 32'd0);
      repeat (3) cycle();

      for (int r = 0; r < 8; r++) begin
         clear_traces();
         run_seq(SW'($urandom), bit'($urandom_range(0, 1)), 1'b0);
         check("rand_done",        32'(done_cnt),    32'd1);
         check("rand_mul_readies", 32'(mul_rdy_cnt), 32'd4);
         check("rand_inv_readies", 32'(inv_rdy_cnt), 32'd3);
      end

      repeat (5) cycle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
